// File: rtl/my_counter_if.sv
// my_counter_if: output bundle of the my_counter LED divider.
//   led_out  - registered square wave, toggles once per count period
//   cnt_flag - one-cycle terminal-count pulse (only with MYCOUNTER_FLAG_EN)
// Modports: master drives the signals (the counter); slave observes them.
// Optional feature macro: MYCOUNTER_FLAG_EN.
interface my_counter_if;
    logic led_out;
`ifdef MYCOUNTER_FLAG_EN
    logic cnt_flag;

    modport master (output led_out, output cnt_flag);
    modport slave  (input  led_out, input  cnt_flag);
`else
    modport master (output led_out);
    modport slave  (input  led_out);
`endif
endinterface

// File: rtl/my_counter.sv
// my_counter: free-running 25-bit divider producing a 50 % duty LED square wave.
// Ports:
//   sys_clk  - system clock, all logic on the rising edge
//   sys_rst  - synchronous active-high reset
//   cnt_if   - my_counter_if.master: led_out, and cnt_flag when enabled
// Parameter:
//   COUNTER_MAX - terminal count; the count period is COUNTER_MAX+1 cycles
// Optional feature macro: MYCOUNTER_FLAG_EN adds the registered cnt_flag pulse,
// high during the single cycle in which cnt == COUNTER_MAX.
module my_counter #(
    parameter logic [24:0] COUNTER_MAX = 25'd24_999_999
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    my_counter_if.master cnt_if
);

    logic [24:0] cnt_q, cnt_d;
    logic        led_q, led_d;
    logic        wrap;

    always_comb begin
        cnt_d = '0;
        wrap  = (cnt_q == COUNTER_MAX);
        // Anything at or above the terminal count returns to zero; only an
        // exact match counts as a wrap, so an out-of-range value never toggles.
        if (cnt_q < COUNTER_MAX) begin
            cnt_d = cnt_q + 25'd1;
        end
        led_d = led_q ^ wrap;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign cnt_if.led_out = led_q;

`ifdef MYCOUNTER_FLAG_EN
    logic flag_q, flag_d;

    // Registered look-ahead: high exactly while cnt_q holds the terminal count.
    always_comb begin
        flag_d = (cnt_d == COUNTER_MAX);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign cnt_if.cnt_flag = flag_q;
`endif

endmodule

// File: tb/tb_my_counter.sv
module tb_my_counter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always #10 sys_clk = ~sys_clk;

    my_counter_if if24 ();
    my_counter_if if0 ();
    my_counter_if ifdef_max ();

    my_counter #(.COUNTER_MAX(25'd24)) dut24 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cnt_if  (if24)
    );

    my_counter #(.COUNTER_MAX(25'd0)) dut0 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cnt_if  (if0)
    );

    my_counter dut_def (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cnt_if  (ifdef_max)
    );

    typedef struct {
        logic        led24;
        logic        led0;
        logic        flag24;
    } exp_t;

    typedef struct {
        logic        rst;
        int unsigned cycles;
        logic        exp24;
        logic        exp0;
        logic        expf;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[13];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_edges  = 0;  // rising edges with sys_rst low since last reset edge

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive reset, push model expectation, then compare after the edge.
    task automatic step(input logic rst);
        exp_t e;
        exp_t got;
        @(negedge sys_clk);
        sys_rst = rst;
        n_edges = rst ? 0 : n_edges + 1;
        e.led24  = ((n_edges / 25) % 2) == 1;
        e.led0   = (n_edges % 2) == 1;
        e.flag24 = (n_edges % 25) == 24;
        sb_q.push_back(e);
        @(posedge sys_clk);
        #1;
        got = sb_q.pop_front();
        check("sb_led24", if24.led_out, got.led24);
        check("sb_led0", if0.led_out, got.led0);
        check("sb_led_default", ifdef_max.led_out, 1'b0);
`ifdef MYCOUNTER_FLAG_EN
        check("sb_flag24", if24.cnt_flag, got.flag24);
`endif
    endtask

    initial begin
        int unsigned last_toggle;
        int unsigned toggles;
        logic        prev_led;
        logic        prev_flag;

        // {rst, cycles, led_out(24) after, led_out(0) after, cnt_flag(24) after}
        vecs[0]  = '{1'b1, 2,   1'b0, 1'b0, 1'b0};  // reset state
        vecs[1]  = '{1'b0, 24,  1'b0, 1'b0, 1'b1};  // n=24: still low, flag up
        vecs[2]  = '{1'b0, 1,   1'b1, 1'b1, 1'b0};  // n=25: first rise
        vecs[3]  = '{1'b0, 24,  1'b1, 1'b1, 1'b1};  // n=49
        vecs[4]  = '{1'b0, 1,   1'b0, 1'b0, 1'b0};  // n=50: fall
        vecs[5]  = '{1'b0, 12,  1'b0, 1'b0, 1'b0};  // n=62 mid-period
        vecs[6]  = '{1'b1, 1,   1'b0, 1'b0, 1'b0};  // abort period
        vecs[7]  = '{1'b0, 24,  1'b0, 1'b0, 1'b1};  // n=24 after restart
        vecs[8]  = '{1'b0, 1,   1'b1, 1'b1, 1'b0};  // n=25: rise
        vecs[9]  = '{1'b0, 25,  1'b0, 1'b0, 1'b0};  // n=50
        vecs[10] = '{1'b0, 250, 1'b0, 1'b0, 1'b0};  // n=300
        vecs[11] = '{1'b0, 13,  1'b0, 1'b1, 1'b0};  // n=313
        vecs[12] = '{1'b0, 12,  1'b1, 1'b1, 1'b0};  // n=325

        for (int i = 0; i < 13; i++) begin
            for (int c = 0; c < int'(vecs[i].cycles); c++) begin
                step(vecs[i].rst);
            end
            check($sformatf("vec%0d_led24", i), if24.led_out, vecs[i].exp24);
            check($sformatf("vec%0d_led0", i), if0.led_out, vecs[i].exp0);
`ifdef MYCOUNTER_FLAG_EN
            check($sformatf("vec%0d_flag24", i), if24.cnt_flag, vecs[i].expf);
`endif
        end

        // Multi-cycle reset held mid-period, then restart.
        for (int c = 0; c < 7; c++) step(1'b0);
        for (int c = 0; c < 3; c++) step(1'b1);
        check("hold_rst_led24", if24.led_out, 1'b0);

        // Ten full periods: every phase must last exactly 25 edges, and the flag
        // must be high in the cycle just before each toggle edge.
        prev_led    = if24.led_out;
        prev_flag   = 1'b0;
        last_toggle = 0;
        toggles     = 0;
        for (int unsigned i = 1; i <= 500; i++) begin
            step(1'b0);
            if (if24.led_out !== prev_led) begin
                toggles++;
                check($sformatf("phase%0d_len", toggles), (i - last_toggle) == 25, 1'b1);
`ifdef MYCOUNTER_FLAG_EN
                check($sformatf("phase%0d_flag_before", toggles), prev_flag, 1'b1);
`endif
                last_toggle = i;
            end
            prev_led = if24.led_out;
`ifdef MYCOUNTER_FLAG_EN
            prev_flag = if24.cnt_flag;
`endif
        end
        check("phase_toggle_count", toggles == 20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_counter.md
MY_COUNTER -- requirements
Module: my_counter

Interface
- REQ-001: Parameter COUNTER_MAX, default 25'd24_999_999, terminal count of the divider (0.5 s at 50 MHz).
- REQ-002: sys_clk  input  1  system clock; all logic on rising edge.
- REQ-003: sys_rst  input  1  reset, synchronous, active-high.
- REQ-004: led_out  output  1  registered square wave, toggles once per count period.
- REQ-005: cnt_flag  output  1  one-cycle terminal-count pulse, present only when MYCOUNTER_FLAG_EN is defined (see Configuration).
- REQ-006: One clock domain; no other ports.

Function
- REQ-007: Internal counter cnt SHALL be 25 bits wide, unsigned.
- REQ-008: Each rising edge with sys_rst low: cnt < COUNTER_MAX -> cnt+1; cnt == COUNTER_MAX -> cnt = 0 (wrap).
- REQ-009: led_out SHALL toggle on the same edge at which cnt wraps (cnt == COUNTER_MAX sampled) and hold otherwise.
- REQ-010: Count period SHALL be COUNTER_MAX+1 cycles; led_out period SHALL be 2*(COUNTER_MAX+1) cycles, 50 % duty.
- REQ-011: COUNTER_MAX = 0: cnt stays 0, led_out toggles every cycle.
- REQ-012: If cnt ever exceeds COUNTER_MAX (not reachable in normal operation), next value SHALL be 0 without toggling led_out.
- REQ-013: led_out SHALL be driven directly from a flip-flop (no combinational output path).
- REQ-014: No enable, load or direction control; counting is free-running while out of reset.

Reset
- REQ-015: sys_rst high at a rising edge: cnt = 0, led_out = 0, cnt_flag = 0 (when present).
- REQ-016: Reset asserted mid-period SHALL abort the period; the count restarts from 0 on the first edge with sys_rst low.
- REQ-017: First led_out toggle after reset release SHALL occur on the (COUNTER_MAX+1)-th rising edge with sys_rst low.
- REQ-018: No asynchronous behaviour; reset changes take effect only at clock edges.

Configuration
- REQ-019: Macro MYCOUNTER_FLAG_EN: when defined, output cnt_flag SHALL exist and be registered high for exactly one cycle, in the cycle cnt == COUNTER_MAX (asserted on the edge where cnt becomes COUNTER_MAX, cleared on the wrap edge).
- REQ-020: When MYCOUNTER_FLAG_EN is undefined, cnt_flag port and logic SHALL be absent; led_out and cnt behaviour SHALL be identical in both builds.

Verification
- REQ-021: COUNTER_MAX=24, 20 ns clock, sys_rst high 20 ns then low -> led_out 0 for 24 edges, rises at 25th edge (500 ns after release), falls at 50th edge; period 1000 ns.
- REQ-022: COUNTER_MAX=24, steady run of 10 periods -> every high and low phase exactly 25 cycles.
- REQ-023: COUNTER_MAX=24, assert sys_rst for 1 cycle at edge 12 after release -> led_out 0, next rise 25 edges after deassertion.
- REQ-024: COUNTER_MAX=0 -> led_out toggles every edge after reset release.
- REQ-025: MYCOUNTER_FLAG_EN defined, COUNTER_MAX=24 -> cnt_flag high exactly 1 cycle every 25, its high cycle immediately preceding each led_out toggle edge; undefined build -> led_out waveform identical.
- REQ-026: Default COUNTER_MAX with 50 MHz clock -> led_out toggles every 25_000_000 cycles (spot-check first toggle).
